// File: rtl/shift_add_mult16.sv
// Sequential 16x16 unsigned shift-and-add multiplier around a single 16-bit
// carry-lookahead adder; one partial-product add per clock, valid/ready on both sides.

module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, pg;
  logic [4:0]  cg;
  logic        c_run;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    pg = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end
  end

  // Group carries fully expanded so no carry ripples between nibbles.
  always_comb begin
    cg[0] = cin;
    cg[1] = gg[0] | (pg[0] & cin);
    cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
    cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & cin);
    cg[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
          | (pg[3] & pg[2] & pg[1] & gg[0]) | (pg[3] & pg[2] & pg[1] & pg[0] & cin);
  end

  always_comb begin
    c     = '0;
    c_run = 1'b0;
    for (int k = 0; k < 4; k++) begin
      c_run = cg[k];
      for (int j = 0; j < 4; j++) begin
        c[4*k+j] = c_run;
        c_run    = g[4*k+j] | (p[4*k+j] & c_run);
      end
    end
  end

  assign sum  = p ^ c;
  assign cout = cg[4];
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready=1
// BUSY  | 16 add/shift iterations in progress
// DONE  | product presented, out_valid=1 until out_ready
module shift_add_mult16 #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  localparam int ITER = WIDTH;

  if (WIDTH != 16) begin : g_bad_width
    $error("shift_add_mult16: WIDTH must be 16 (datapath is bound to cla16)");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] mcand, acc_hi, acc_lo, addend, sum;
  logic [4:0]  cnt;
  logic        cout, accept, last_iter;

  assign accept    = (state == IDLE) && in_valid;
  assign last_iter = (cnt == 5'(ITER - 1));
  assign addend    = acc_lo[0] ? mcand : 16'd0;

  cla16 u_cla (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // The adder carry is kept as the new MSB so the 33-bit partial sum shifts right intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else if (accept) begin
      mcand  <= a;
      acc_hi <= '0;
      acc_lo <= b;
      cnt    <= '0;
    end else if (state == BUSY) begin
      {acc_hi, acc_lo} <= {cout, sum, acc_lo[15:1]};
      cnt              <= cnt + 5'd1;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign product   = {acc_hi, acc_lo};
endmodule

// File: tb/tb_shift_add_mult16.sv
// Bench for shift_add_mult16: a transaction-level reference model checked every
// cycle, plus directed operand vectors with hand-computed products.

module tb_shift_add_mult16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid;
  logic [31:0] product;

  int n_cmp = 0, n_err = 0;
  int n_acc = 0, n_out = 0, exp_outs = 0;
  bit check_en = 1'b0;

  shift_add_mult16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted pair yields a*b sixteen edges later, held until taken.
  int          m_rem;
  logic [31:0] m_pend, m_prod;
  bit          m_in_ready, m_out_valid, m_prod_known;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_ready   <= 1'b1;
      m_out_valid  <= 1'b0;
      m_rem        <= 0;
      m_prod       <= '0;
      m_pend       <= '0;
      m_prod_known <= 1'b1;
    end else if (m_in_ready && in_valid) begin
      m_in_ready   <= 1'b0;
      m_rem        <= 16;
      m_pend       <= 32'(a) * 32'(b);
      m_prod_known <= 1'b0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_out_valid  <= 1'b1;
        m_prod       <= m_pend;
        m_prod_known <= 1'b1;
      end
    end else if (m_out_valid && out_ready) begin
      m_out_valid <= 1'b0;
      m_in_ready  <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready)   n_acc++;
    if (rst_n && out_valid && out_ready) n_out++;
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_in_ready", in_ready, m_in_ready);
      chk("cyc_out_valid", out_valid, m_out_valid);
      if (m_prod_known) chk("cyc_product", product, m_prod);
    end
  end

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input int hold,
                        output logic [31:0] p, output int lat, output int low);
    out_ready = (hold == 0);
    @(negedge clk);
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    low = in_ready ? 0 : 1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!in_ready) low++;
    end
    p = product;
    exp_outs++;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        a = ~ta; b = ~tb_v; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("hold_out_valid", out_valid, 1'b1);
        chk("hold_product", product, p);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_out_valid", out_valid, 1'b0);
      chk("release_in_ready", in_ready, 1'b1);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] p;
  int          lat, low;
  logic [15:0] ra, rb;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_product", product, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(16'd10, 16'd5, 0, p, lat, low);
    chk("t1_product", p, 32'd50);
    chk("t1_latency", lat, 32'd16);
    chk("t1_in_ready_low", low, 32'd17);

    run_op(16'hFFFF, 16'hFFFF, 0, p, lat, low);
    chk("ffff_product", p, 32'hFFFE0001);
    run_op(16'd1234, 16'd5662, 0, p, lat, low);
    chk("1234_product", p, 32'h006A9C9C);
    run_op(16'd0, 16'hABCD, 0, p, lat, low);
    chk("zero_product", p, 32'd0);
    run_op(16'h8000, 16'd2, 0, p, lat, low);
    chk("8000_product", p, 32'h00010000);
    chk("8000_latency", lat, 32'd16);

    run_op(16'd300, 16'd400, 10, p, lat, low);
    chk("bp_product", p, 32'h0001D4C0);
    run_op(16'd77, 16'd13, 0, p, lat, low);
    chk("after_bp_product", p, 32'd1001);

    // Start an operation, then pull reset between edges after 7 busy cycles.
    @(negedge clk);
    a = 16'd100; b = 16'd200; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_product", product, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(16'd3, 16'd7, 0, p, lat, low);
    chk("post_rst_product", p, 32'd21);
    chk("post_rst_latency", lat, 32'd16);

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, 0, p, lat, low);
      chk("rand_product", p, 32'(ra) * 32'(rb));
      chk("rand_latency", lat, 32'd16);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("outputs_delivered", n_out, exp_outs);
    chk("accepts_seen", n_acc, exp_outs + 1);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
